// File: rtl/bnn_pkg.sv
// Shared types and helpers for the binary neural network datapath blocks.
package bnn_pkg;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } pack_state_t;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/bfeat_packer.sv
// Packs an MSB-first stream of WORD_W-bit words into one ISIZE_FEAT-bit binary
// feature vector and holds it until the fully connected layer takes it.
module bfeat_packer
    import bnn_pkg::*;
#(
    parameter int ISIZE_FEAT = 16,
    parameter int WORD_W     = 4,
    localparam int NWORDS    = ceil_div(ISIZE_FEAT, WORD_W),
    localparam int CNT_W     = $clog2(NWORDS + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic [WORD_W-1:0]     word_i,
    input  logic                  word_valid_i,
    output logic                  word_ready_o,
    output logic [ISIZE_FEAT-1:0] feat_o,
    output logic                  feat_valid_o,
    input  logic                  feat_ready_i,
    output logic [CNT_W-1:0]      word_cnt_o
);

    pack_state_t           state;
    logic [CNT_W-1:0]      cnt;
    logic [ISIZE_FEAT-1:0] feat;
    logic [ISIZE_FEAT-1:0] bit_load;
    logic [ISIZE_FEAT-1:0] bit_src;
    logic [ISIZE_FEAT-1:0] feat_next;
    logic                  accept;
    logic                  last_word;

    assign word_ready_o = (state == FILL);
    assign feat_valid_o = (state == HOLD);
    assign feat_o       = feat;
    assign word_cnt_o   = cnt;

    assign accept    = word_valid_i && word_ready_o;
    assign last_word = (cnt == CNT_W'(NWORDS - 1));

    // Each output bit knows statically which word and which word bit feeds it;
    // low bits of a short final word simply have no destination.
    for (genvar i = 0; i < ISIZE_FEAT; i++) begin : g_bit
        localparam int POS  = ISIZE_FEAT - 1 - i;
        localparam int WIDX = POS / WORD_W;
        localparam int WBIT = WORD_W - 1 - (POS % WORD_W);
        assign bit_load[i] = accept && (cnt == CNT_W'(WIDX));
        assign bit_src[i]  = word_i[WBIT];
    end

    assign feat_next = (feat & ~bit_load) | (bit_src & bit_load);

    // Clear outranks both a word accept and an output handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= FILL;
            cnt   <= '0;
            feat  <= '0;
        end else if (clear_i) begin
            state <= FILL;
            cnt   <= '0;
            feat  <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        feat <= feat_next;
                        cnt  <= cnt + CNT_W'(1);
                        if (last_word) begin
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (feat_ready_i) begin
                        state <= FILL;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= FILL;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bfeat_packer.sv
// Directed bench for bfeat_packer: a 10-bit/4-bit instance (three words, short
// last word) and a 4-bit/4-bit instance (one word per vector).
module tb_bfeat_packer;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       a_clear;
    logic [3:0] a_word;
    logic       a_word_valid;
    logic       a_word_ready;
    logic [9:0] a_feat;
    logic       a_feat_valid;
    logic       a_feat_ready;
    logic [1:0] a_word_cnt;

    logic       b_clear;
    logic [3:0] b_word;
    logic       b_word_valid;
    logic       b_word_ready;
    logic [3:0] b_feat;
    logic       b_feat_valid;
    logic       b_feat_ready;
    logic [0:0] b_word_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bfeat_packer #(.ISIZE_FEAT(10), .WORD_W(4)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(a_clear),
        .word_i(a_word), .word_valid_i(a_word_valid), .word_ready_o(a_word_ready),
        .feat_o(a_feat), .feat_valid_o(a_feat_valid), .feat_ready_i(a_feat_ready),
        .word_cnt_o(a_word_cnt)
    );

    bfeat_packer #(.ISIZE_FEAT(4), .WORD_W(4)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(b_clear),
        .word_i(b_word), .word_valid_i(b_word_valid), .word_ready_o(b_word_ready),
        .feat_o(b_feat), .feat_valid_o(b_feat_valid), .feat_ready_i(b_feat_ready),
        .word_cnt_o(b_word_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        tests++;
        if (a_feat !== 10'h000 || a_feat_valid !== 1'b0 || a_word_cnt !== 2'd0 || a_word_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL reset_a: feat=%h valid=%b cnt=%0d ready=%b, want 000 0 0 1",
                     a_feat, a_feat_valid, a_word_cnt, a_word_ready);
        end
        tests++;
        if (b_feat !== 4'h0 || b_feat_valid !== 1'b0 || b_word_cnt !== 1'd0 || b_word_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL reset_b: feat=%h valid=%b cnt=%0d ready=%b, want 0 0 0 1",
                     b_feat, b_feat_valid, b_word_cnt, b_word_ready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_pack();
        logic [3:0] words [3];
        words[0] = 4'hA; words[1] = 4'h5; words[2] = 4'hC;
        a_feat_ready = 1'b1;
        a_word_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            a_word = words[k];
            tick();
            tests++;
            if (a_word_cnt !== 2'(k + 1) || a_feat_valid !== (k == 2)) begin
                fails++;
                $display("[TB] FAIL pack_word%0d: cnt=%0d valid=%b, want %0d %b",
                         k, a_word_cnt, a_feat_valid, k + 1, (k == 2));
            end
        end
        a_word_valid = 1'b0;
        tests++;
        if (a_feat !== 10'h297 || a_word_ready !== 1'b0) begin
            fails++;
            $display("[TB] FAIL pack_result: feat=%h ready=%b, want 297 0", a_feat, a_word_ready);
        end
        tick();
        tests++;
        if (a_feat_valid !== 1'b0 || a_word_ready !== 1'b1 || a_word_cnt !== 2'd0 || a_feat !== 10'h297) begin
            fails++;
            $display("[TB] FAIL pack_release: valid=%b ready=%b cnt=%0d feat=%h, want 0 1 0 297",
                     a_feat_valid, a_word_ready, a_word_cnt, a_feat);
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] words [3];
        words[0] = 4'hA; words[1] = 4'h5; words[2] = 4'hC;
        a_feat_ready = 1'b0;
        a_word_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            a_word = words[k];
            tick();
        end
        a_word = 4'h3;
        for (int c = 0; c < 5; c++) begin
            tick();
            tests++;
            if (a_word_ready !== 1'b0 || a_feat_valid !== 1'b1 || a_feat !== 10'h297 || a_word_cnt !== 2'd3) begin
                fails++;
                $display("[TB] FAIL hold_cycle%0d: ready=%b valid=%b feat=%h cnt=%0d, want 0 1 297 3",
                         c, a_word_ready, a_feat_valid, a_feat, a_word_cnt);
            end
        end
        a_feat_ready = 1'b1;
        a_word_valid = 1'b0;
        tick();
        tests++;
        if (a_word_ready !== 1'b1 || a_feat_valid !== 1'b0 || a_word_cnt !== 2'd0) begin
            fails++;
            $display("[TB] FAIL hold_release: ready=%b valid=%b cnt=%0d, want 1 0 0",
                     a_word_ready, a_feat_valid, a_word_cnt);
        end
    endtask

    task automatic test_clear();
        a_feat_ready = 1'b1;
        a_word_valid = 1'b1;
        a_word = 4'hA; tick();
        a_word = 4'h5; tick();
        a_word = 4'hC;
        a_clear = 1'b1;
        tick();
        a_clear = 1'b0;
        a_word_valid = 1'b0;
        tests++;
        if (a_word_cnt !== 2'd0 || a_feat !== 10'h000 || a_feat_valid !== 1'b0 || a_word_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL clear_partial: cnt=%0d feat=%h valid=%b ready=%b, want 0 000 0 1",
                     a_word_cnt, a_feat, a_feat_valid, a_word_ready);
        end
        a_feat_ready = 1'b0;
        a_word_valid = 1'b1;
        a_word = 4'hF; tick();
        a_word = 4'hF; tick();
        a_word = 4'hF; tick();
        a_word_valid = 1'b0;
        tests++;
        if (a_feat !== 10'h3FF || a_feat_valid !== 1'b1) begin
            fails++;
            $display("[TB] FAIL clear_setup: feat=%h valid=%b, want 3ff 1", a_feat, a_feat_valid);
        end
        a_feat_ready = 1'b1;
        a_clear = 1'b1;
        tick();
        a_clear = 1'b0;
        tests++;
        if (a_feat !== 10'h000 || a_feat_valid !== 1'b0 || a_word_cnt !== 2'd0) begin
            fails++;
            $display("[TB] FAIL clear_hold: feat=%h valid=%b cnt=%0d, want 000 0 0",
                     a_feat, a_feat_valid, a_word_cnt);
        end
    endtask

    task automatic test_async_reset();
        a_feat_ready = 1'b1;
        a_word_valid = 1'b1;
        a_word = 4'hF;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (a_word_cnt !== 2'd0 || a_feat !== 10'h000 || a_word_ready !== 1'b1 || a_feat_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL async_reset: cnt=%0d feat=%h ready=%b valid=%b, want 0 000 1 0",
                     a_word_cnt, a_feat, a_word_ready, a_feat_valid);
        end
        #1;
        rst_n = 1'b1;
        a_word = 4'hF; tick();
        a_word = 4'h0; tick();
        a_word = 4'h4; tick();
        a_word_valid = 1'b0;
        tests++;
        if (a_feat !== 10'h3C1 || a_feat_valid !== 1'b1) begin
            fails++;
            $display("[TB] FAIL after_reset: feat=%h valid=%b, want 3c1 1", a_feat, a_feat_valid);
        end
        tick();
    endtask

    task automatic test_single_word();
        logic [3:0] words [3];
        words[0] = 4'h9; words[1] = 4'h6; words[2] = 4'h3;
        b_feat_ready = 1'b1;
        b_word_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            b_word = words[k];
            tick();
            tests++;
            if (b_feat_valid !== 1'b1 || b_feat !== words[k] || b_word_ready !== 1'b0) begin
                fails++;
                $display("[TB] FAIL single_vec%0d: valid=%b feat=%h ready=%b, want 1 %h 0",
                         k, b_feat_valid, b_feat, b_word_ready, words[k]);
            end
            tick();
            tests++;
            if (b_feat_valid !== 1'b0 || b_word_ready !== 1'b1 || b_feat !== words[k]) begin
                fails++;
                $display("[TB] FAIL single_gap%0d: valid=%b ready=%b feat=%h, want 0 1 %h",
                         k, b_feat_valid, b_word_ready, b_feat, words[k]);
            end
        end
        b_word_valid = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b0;
        a_clear      = 1'b0;
        a_word       = 4'h0;
        a_word_valid = 1'b0;
        a_feat_ready = 1'b0;
        b_clear      = 1'b0;
        b_word       = 4'h0;
        b_word_valid = 1'b0;
        b_feat_ready = 1'b0;

        test_reset();
        test_pack();
        test_backpressure();
        test_clear();
        test_async_reset();
        test_single_word();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
